segasys1_prgrom_ctl: RTL
========================

Name: segasys1_prgrom_ctl

Overview:
Parametrised main-CPU program ROM controller for System 1/2 boards.
- Merges plain, Type 1 and Type 2 decryption into one block; the mode is selected at run time.
- Adds a banked window at $8000-$BFFF and a request/ready handshake, so the Z80 wrapper can insert wait states.
- Sits between the main Z80 bus and the downloaded ROM images; it is also the write target for the ROM download stream.

Parameters:
- MAIN_AW, 15, address width of the encrypted region at $0000-$7FFF (32 KB).
- BANK_AW, 14, address width of one bank in the window at $8000-$BFFF (16 KB).
- NBANKS, 4, number of banks; must be a power of two, 1..8.
- DL_BANKBASE, 18'h08000, download address of bank 0; bank n is at DL_BANKBASE + n*2^BANK_AW.
- DL_TBL0, 18'h2C100, download base of the Type 1 table and the Type 2 XOR table (128 bytes).
- DL_TBL1, 18'h2C180, download base of the Type 2 swap-select table (128 bytes).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mode  in  2  0 = plain, 1 = Type 1, 2 = Type 2, 3 = treated as plain
- cpu_req  in  1  single-cycle access strobe; cpu_ad and cpu_m1 are valid in the same cycle
- cpu_m1  in  1  opcode-fetch flag
- cpu_ad  in  16  CPU address
- cpu_dt  out  8  read data; held until the next completed access
- cpu_rdy  out  1  one-cycle pulse marking cpu_dt valid
- bank_wr  in  1  bank-register write strobe
- bank_dt  in  3  new bank index; bits above log2(NBANKS) are ignored
- dl_en  in  1  download in progress
- dl_wr  in  1  download byte strobe
- dl_ad  in  25  download byte address
- dl_dt  in  8  download byte

Behaviour:
Reset values:
- cpu_dt = 8'h00, cpu_rdy = 0, bank = 0, state = IDLE.
- ROM and table contents are not cleared.

State machine: IDLE -> RD -> DEC -> DONE -> IDLE.
- IDLE: on cpu_req with dl_en = 0, latch cpu_ad, cpu_m1 and the current bank, then go to RD. cpu_req while dl_en = 1 is dropped; the wrapper must re-issue it.
- RD: the ROM array is addressed and data is registered.
  - Encrypted region with mode 1 or 2: go to DEC.
  - All other accesses: go to DONE.
- DEC: the table is addressed from the registered ROM data and latched address; the table output is registered.
- DONE: drive the result onto cpu_dt, pulse cpu_rdy for one cycle, return to IDLE.

Latency from cpu_req to cpu_rdy:
- 3 cycles for an encrypted decode.
- 2 cycles for plain, banked or unmapped accesses.

Address decode:
- $0000-$7FFF: main ROM, decrypted according to mode.
- $8000-$BFFF: bank ROM, addressed as {bank, ad[13:0]}; never decrypted.
- $C000-$FFFF: returns 8'hFF after 2 cycles (no ROM access).

Type 1 decryption (d = ROM byte, f = d[7]):
- idx = {a12, a8, a4, a0, ~m1, d5^f, d3^f}.
- out = (d & 8'h57) | (tbl[idx] ^ {f, 0, f, 0, f, 3'b000}).

Type 2 decryption:
- idx = {a14, a12, a9, a6, a3, a0, m1}.
- s = swap[idx][4:0]; x = xor[idx].
- out = perm(s, d) ^ x.
- perm keeps bits 7, 5, 3 and 1 in place and places source bits 6/4/2/0 per the 24-entry list.
- s >= 24 gives perm = 8'h00.

Bank register:
- bank_wr writes the bank index modulo NBANKS; this takes effect from the next cycle.
- An access already past IDLE uses the bank latched at request. A bank_wr in the same cycle as cpu_req: the request uses the old bank.

Download writes (dl_wr with dl_en = 1):
- Main ROM when dl_ad[17:MAIN_AW] = 0.
- Bank n when dl_ad falls in [DL_BANKBASE + n*16K, DL_BANKBASE + (n+1)*16K).
- Tables when dl_ad[17:7] matches DL_TBL0 or DL_TBL1.
- All other addresses are ignored. dl_ad[24:18] must be 0.
- Rising edge of dl_en while an access is in flight: the access completes normally.

Reset asserted mid-access: the access is abandoned; no cpu_rdy is issued.

mode changes: sampled at the RD state only; a change mid-access does not corrupt that access.

Decomposition:
- Shared package segasys1_prgrom_pkg:
  - mode encoding constants (MODE_PLAIN, MODE_T1, MODE_T2)
  - state enum
  - Type 1 AND/XOR masks
  - 24-entry Type 2 permutation list and the perm function
  - download base constants
- One sub-module, segasys1_dlram: single-clock, download-writable synchronous RAM, parametrised in address width.
  - Instantiated for main ROM, bank ROM (BANK_AW + log2 NBANKS bits), table 0 and table 1.

Test Plan:
- Plain mode: download main[$1234] = 8'h5A, then cpu_req at $1234 -> cpu_rdy 2 cycles later, cpu_dt = 8'h5A.
- Type 1: tbl[7'h08] = 8'h20, main[$0000] = 8'h00, m1 = 1 -> idx = 7'h00, wrong entry. Instead set tbl[7'h00] = 8'h20 -> cpu_dt = 8'h20 at 3-cycle latency. Repeat with m1 = 0 and tbl[7'h04] = 8'h01 -> 8'h01.
- Type 2: swap[7'h01] = 1, xor[7'h01] = 8'h00, main[$0000] = 8'h40, m1 = 1 -> perm gives 8'h10. Then swap[7'h01] = 30 -> cpu_dt = 8'h00.
- Banking with NBANKS = 4: bank n byte at $8010 = n; bank_wr 2, read $8010 -> 8'h02. bank_wr 6 -> bank 2 -> 8'h02. Read $C000 -> 8'hFF.
- Boundaries:
  - bank_wr in the same cycle as cpu_req -> old bank data.
  - reset pulse in state DEC -> no cpu_rdy, cpu_dt = 0.
  - cpu_req during dl_en = 1 -> no cpu_rdy.

Source files
------------

// File: rtl/segasys1_prgrom_pkg.sv
// Shared constants and helpers for the System 1/2 main-CPU program ROM controller.
package segasys1_prgrom_pkg;

    // Decryption mode select; any other value behaves as plain.
    localparam logic [1:0] MODE_PLAIN = 2'd0;
    localparam logic [1:0] MODE_T1    = 2'd1;
    localparam logic [1:0] MODE_T2    = 2'd2;

    // Access sequencer states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_DEC  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Type 1: bits passed straight through from the ROM byte, and the bits of
    // the table entry flipped when the ROM byte has bit 7 set.
    localparam logic [7:0] T1_KEEP_MASK = 8'h57;
    localparam logic [7:0] T1_FLIP_MASK = 8'hA8;

    // Default download map.
    localparam logic [17:0] DL_BANKBASE_DEF = 18'h08000;
    localparam logic [17:0] DL_TBL0_DEF     = 18'h2C100;
    localparam logic [17:0] DL_TBL1_DEF     = 18'h2C180;

    // Type 2 permutation list. The even bits 6/4/2/0 are lanes 3/2/1/0.
    // Each entry holds, per destination lane, the source lane it takes:
    // {lane3, lane2, lane1, lane0}. Entry n is the n-th permutation in
    // lexicographic order of the tuple (lane0, lane1, lane2, lane3).
    localparam int T2_NPERM = 24;
    localparam logic [7:0] T2_PERM [T2_NPERM] = '{
        8'b11_10_01_00, 8'b10_11_01_00, 8'b11_01_10_00, 8'b01_11_10_00,
        8'b10_01_11_00, 8'b01_10_11_00, 8'b11_10_00_01, 8'b10_11_00_01,
        8'b11_00_10_01, 8'b00_11_10_01, 8'b10_00_11_01, 8'b00_10_11_01,
        8'b11_01_00_10, 8'b01_11_00_10, 8'b11_00_01_10, 8'b00_11_01_10,
        8'b01_00_11_10, 8'b00_01_11_10, 8'b10_01_00_11, 8'b01_10_00_11,
        8'b10_00_01_11, 8'b00_10_01_11, 8'b01_00_10_11, 8'b00_01_10_11
    };

    // Type 2 bit shuffle: odd bits stay, even bits are routed per list entry s.
    // Selectors past the end of the list yield zero.
    function automatic logic [7:0] t2_perm(input logic [4:0] s, input logic [7:0] d);
        logic [7:0] sel;
        logic [7:0] r;
        sel = 8'h00;
        r   = 8'h00;
        if (s < 5'(T2_NPERM)) begin
            sel  = T2_PERM[s];
            r    = d & 8'hAA;
            r[0] = d[{sel[1:0], 1'b0}];
            r[2] = d[{sel[3:2], 1'b0}];
            r[4] = d[{sel[5:4], 1'b0}];
            r[6] = d[{sel[7:6], 1'b0}];
        end
        return r;
    endfunction

endpackage

// File: rtl/segasys1_dlram.sv
// Byte-wide synchronous RAM with an independent write port for the ROM
// download stream and a registered read port for the CPU side.
module segasys1_dlram #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [7:0]    wd,
    input  logic [AW-1:0] ra,
    output logic [7:0]    rd
);

    logic [7:0] mem [2**AW];
    logic [7:0] rd_q;

    // Download write and registered read share the single clock.
    // NOTE: the array has no reset; clearing a RAM takes one write per word
    // and the contents only become meaningful once downloaded anyway.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
        rd_q <= mem[ra];
    end

    assign rd = rd_q;

endmodule

// File: rtl/segasys1_prgrom_ctl.sv
// Main-CPU program ROM controller: plain/Type 1/Type 2 decryption of
// $0000-$7FFF, banked window at $8000-$BFFF, $FF above, with a
// request/ready handshake and download write decode.
module segasys1_prgrom_ctl
    import segasys1_prgrom_pkg::*;
#(
    parameter int          MAIN_AW     = 15,
    parameter int          BANK_AW     = 14,
    parameter int          NBANKS      = 4,
    parameter logic [17:0] DL_BANKBASE = DL_BANKBASE_DEF,
    parameter logic [17:0] DL_TBL0     = DL_TBL0_DEF,
    parameter logic [17:0] DL_TBL1     = DL_TBL1_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mode,
    input  logic        cpu_req,
    input  logic        cpu_m1,
    input  logic [15:0] cpu_ad,
    output logic [7:0]  cpu_dt,
    output logic        cpu_rdy,
    input  logic        bank_wr,
    input  logic [2:0]  bank_dt,
    input  logic        dl_en,
    input  logic        dl_wr,
    input  logic [24:0] dl_ad,
    input  logic [7:0]  dl_dt
);

    localparam int BANK_BITS = (NBANKS > 1) ? $clog2(NBANKS) : 0;
    localparam int BKW       = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int BANK_RAW  = BANK_AW + BANK_BITS;
    localparam logic [BKW-1:0] BANK_MASK = BKW'(NBANKS - 1);
    localparam logic [18:0]    BANK_SPAN = 19'(NBANKS) << BANK_AW;

    logic [1:0]     state_q, state_d;
    logic [15:0]    ad_q, ad_d;
    logic           m1_q, m1_d;
    logic [BKW-1:0] abank_q, abank_d;
    logic [BKW-1:0] bank_q, bank_d;
    logic [1:0]     mode_q, mode_d;
    logic [7:0]     rom_q, rom_d;
    logic [7:0]     cpu_dt_q, cpu_dt_d;
    logic           cpu_rdy_q, cpu_rdy_d;

    // ---------------- read addressing ----------------
    logic [15:0]            ad_rd;
    logic [BKW-1:0]         bank_rd;
    logic [BANK_AW+BKW-1:0] bank_full;
    logic [7:0]             main_rdat, bank_rdat, tbl0_rdat, tbl1_rdat;
    logic [6:0]             t1_idx, t2_idx, tbl0_ra;
    logic                   f_bit;

    // The ROMs are addressed straight from the bus while idle so their data
    // is already registered by the time the sequencer is in RD.
    always_comb begin
        ad_rd     = (state_q == ST_IDLE) ? cpu_ad : ad_q;
        bank_rd   = (state_q == ST_IDLE) ? bank_q : abank_q;
        bank_full = {bank_rd, ad_rd[BANK_AW-1:0]};
    end

    // Decryption table indices, formed during RD from the ROM byte and latched address.
    always_comb begin
        f_bit   = main_rdat[7];
        t1_idx  = {ad_q[12], ad_q[8], ad_q[4], ad_q[0], ~m1_q,
                   main_rdat[5] ^ f_bit, main_rdat[3] ^ f_bit};
        t2_idx  = {ad_q[14], ad_q[12], ad_q[9], ad_q[6], ad_q[3], ad_q[0], m1_q};
        tbl0_ra = (mode == MODE_T1) ? t1_idx : t2_idx;
    end

    // ---------------- download write decode ----------------
    logic        dl_ok, main_we, bank_we, tbl0_we, tbl1_we;
    logic [18:0] bank_off;

    // Route each download byte to the one image its address falls in.
    always_comb begin
        dl_ok    = dl_en && dl_wr && (dl_ad[24:18] == '0);
        bank_off = {1'b0, dl_ad[17:0]} - {1'b0, DL_BANKBASE};
        main_we  = dl_ok && (dl_ad[17:MAIN_AW] == '0);
        bank_we  = dl_ok && (dl_ad[17:0] >= DL_BANKBASE) && (bank_off < BANK_SPAN);
        tbl0_we  = dl_ok && (dl_ad[17:7] == DL_TBL0[17:7]);
        tbl1_we  = dl_ok && (dl_ad[17:7] == DL_TBL1[17:7]);
    end

    segasys1_dlram #(.AW(MAIN_AW)) u_main (
        .clk(clk), .we(main_we), .wa(dl_ad[MAIN_AW-1:0]), .wd(dl_dt),
        .ra(ad_rd[MAIN_AW-1:0]), .rd(main_rdat)
    );

    segasys1_dlram #(.AW(BANK_RAW)) u_bank (
        .clk(clk), .we(bank_we), .wa(bank_off[BANK_RAW-1:0]), .wd(dl_dt),
        .ra(bank_full[BANK_RAW-1:0]), .rd(bank_rdat)
    );

    segasys1_dlram #(.AW(7)) u_tbl0 (
        .clk(clk), .we(tbl0_we), .wa(dl_ad[6:0]), .wd(dl_dt),
        .ra(tbl0_ra), .rd(tbl0_rdat)
    );

    segasys1_dlram #(.AW(7)) u_tbl1 (
        .clk(clk), .we(tbl1_we), .wa(dl_ad[6:0]), .wd(dl_dt),
        .ra(t2_idx), .rd(tbl1_rdat)
    );

    // ---------------- decryption ----------------
    logic [7:0] dec_out;

    // Final decoded byte, valid during DEC from the held ROM byte and table outputs.
    always_comb begin
        if (mode_q == MODE_T1) begin
            dec_out = (rom_q & T1_KEEP_MASK) |
                      (tbl0_rdat ^ (rom_q[7] ? T1_FLIP_MASK : 8'h00));
        end else begin
            dec_out = t2_perm(tbl1_rdat[4:0], rom_q) ^ tbl0_rdat;
        end
    end

    // ---------------- sequencer ----------------
    // Access sequencing: latch request, read ROM, optional decode, present result.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves one unassigned and infers a latch.
        state_d   = state_q;
        ad_d      = ad_q;
        m1_d      = m1_q;
        abank_d   = abank_q;
        mode_d    = mode_q;
        rom_d     = rom_q;
        cpu_dt_d  = cpu_dt_q;
        cpu_rdy_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req && !dl_en) begin
                    ad_d    = cpu_ad;
                    m1_d    = cpu_m1;
                    abank_d = bank_q;
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                mode_d = mode;
                rom_d  = main_rdat;
                if (!ad_q[15] && (mode == MODE_T1 || mode == MODE_T2)) begin
                    state_d = ST_DEC;
                end else begin
                    if (!ad_q[15]) begin
                        cpu_dt_d = main_rdat;
                    end else if (!ad_q[14]) begin
                        cpu_dt_d = bank_rdat;
                    end else begin
                        cpu_dt_d = 8'hFF;
                    end
                    cpu_rdy_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DEC: begin
                cpu_dt_d  = dec_out;
                cpu_rdy_d = 1'b1;
                state_d   = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bank register: index taken modulo NBANKS.
    always_comb begin
        bank_d = bank_q;
        if (bank_wr) begin
            bank_d = (NBANKS > 1) ? (bank_dt[BKW-1:0] & BANK_MASK) : '0;
        end
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ad_q      <= '0;
            m1_q      <= 1'b0;
            abank_q   <= '0;
            bank_q    <= '0;
            mode_q    <= MODE_PLAIN;
            rom_q     <= 8'h00;
            cpu_dt_q  <= 8'h00;
            cpu_rdy_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q   <= state_d;
            ad_q      <= ad_d;
            m1_q      <= m1_d;
            abank_q   <= abank_d;
            bank_q    <= bank_d;
            mode_q    <= mode_d;
            rom_q     <= rom_d;
            cpu_dt_q  <= cpu_dt_d;
            cpu_rdy_q <= cpu_rdy_d;
        end
    end

    assign cpu_dt  = cpu_dt_q;
    assign cpu_rdy = cpu_rdy_q;

    // Address bits that carry no information for this configuration.
    logic unused_bits;
    assign unused_bits = ^{bank_dt, tbl1_rdat[7:5], bank_off, ad_rd[15], bank_full};

endmodule
